// File: rtl/fetch_queue.sv
// Instruction fetch queue: a DEPTH-entry FIFO of {pc, instr} between fetch and decode.
// Optional same-cycle empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  input  logic                       out_ready,
  input  logic                       Flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Handshake: a beat transfers on a rising edge when valid && ready are both high
  // and Flush is low; valid never depends on ready, and in_ready comes from registered count only.

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count_q;
  logic          empty;
  logic          full;
  logic          bypass;
  logic          push;
  logic          pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !full;
  assign count    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && in_valid && !Flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed beat that decode takes this cycle is never stored.
  assign push = in_valid && in_ready && !Flush && !(bypass && out_ready);
  assign pop  = !empty && out_ready && !Flush;

  always_comb begin
    out_valid = 1'b0;
    out_pc    = 32'h0;
    out_instr = NOP;
    if (!empty) begin
      out_valid = 1'b1;
      out_pc    = pc_mem[head];
      out_instr = instr_mem[head];
    end else if (bypass) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      pc_mem[tail]    <= in_pc;
      instr_mem[tail] <= in_instr;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally at DEPTH-1.
  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
